// File: rtl/cnt_run_ctrl_if.sv
// Counter-side and result-side signal bundle for cnt_run_ctrl.
// The master is the controller; the slave is the counter plus the result consumer.
interface cnt_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             ctr_clr;
  logic             ctr_en;
  logic [CNT_W-1:0] cnt;
  logic             cnt_max;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_data;
  logic             res_ovf;

  modport master (
    output ctr_clr, ctr_en, res_valid, res_data, res_ovf,
    input  cnt, cnt_max, res_ready
  );

  modport slave (
    input  ctr_clr, ctr_en, res_valid, res_data, res_ovf,
    output cnt, cnt_max, res_ready
  );
endinterface

// File: rtl/cnt_run_ctrl.sv
// Run sequencer for a free-running event counter: clear, count to target or saturation, report.
// Optional build macro CNT_RUN_CTRL_AUTORELOAD_EN: a result handshake restarts with the same target.
module cnt_run_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] target,
  input  logic             evt,
  output logic             busy,
  cnt_run_ctrl_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StClr, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] res_data_q, res_data_d;
  logic             res_ovf_q, res_ovf_d;
  logic             hit, sat;
  logic             ctr_clr, ctr_en, res_valid;

  // Target 0 means "run to saturation", so a zero target never produces a hit.
  assign hit = (tgt_q != '0) && (bus.cnt == tgt_q);
  assign sat = (tgt_q == '0) && bus.cnt_max;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    ctr_clr    = 1'b0;
    ctr_en     = 1'b0;
    busy       = 1'b0;
    res_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          tgt_d   = target;
          state_d = StClr;
        end
      end
      StClr: begin
        ctr_clr = 1'b1;
        busy    = 1'b1;
        state_d = abort ? StIdle : StRun;
      end
      StRun: begin
        busy   = 1'b1;
        // Gating on hit/sat keeps the counter from passing target or wrapping.
        ctr_en = evt && !hit && !sat && !abort;
        if (abort) begin
          state_d = StIdle;
        end else if (hit) begin
          res_data_d = bus.cnt;
          res_ovf_d  = 1'b0;
          state_d    = StDone;
        end else if (sat) begin
          res_data_d = bus.cnt;
          res_ovf_d  = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (bus.res_ready) begin
`ifdef CNT_RUN_CTRL_AUTORELOAD_EN
          state_d = StClr;
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // Decoded outputs read as idle while reset is held.
    if (rst) begin
      ctr_clr   = 1'b0;
      ctr_en    = 1'b0;
      busy      = 1'b0;
      res_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tgt_q      <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      res_data_q <= res_data_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  assign bus.ctr_clr   = ctr_clr;
  assign bus.ctr_en    = ctr_en;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// Self-checking bench for cnt_run_ctrl: behavioural counter, run model, directed and random stimulus.
module tb_cnt_run_ctrl;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, abort, evt, res_ready, busy;
  logic [W-1:0] target;

  always #5 clk = ~clk;

  cnt_run_ctrl_if #(.CNT_W(W)) bus_if ();

  cnt_run_ctrl #(.CNT_W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .target(target),
    .evt   (evt),
    .busy  (busy),
    .bus   (bus_if.master)
  );

  // Counter environment with backdoor preload
  logic [W-1:0] cnt_m = '0;
  logic         preload_req;
  logic [W-1:0] preload_val;

  assign bus_if.cnt       = cnt_m;
  assign bus_if.cnt_max   = &cnt_m;
  assign bus_if.res_ready = res_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Run model: a run is clearing, counting, or holding a result.
  bit           m_clearing = 1'b0, m_running = 1'b0, m_holding = 1'b0;
  logic [W-1:0] m_tgt  = '0;
  logic [W-1:0] m_data = '0;
  logic         m_ovf  = 1'b0;

  function automatic bit m_reached();
    return (m_tgt != '0) ? (cnt_m == m_tgt) : (&cnt_m);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_clearing = 1'b0; m_running = 1'b0; m_holding = 1'b0;
      m_tgt = '0; m_data = '0; m_ovf = 1'b0;
    end else if (!(m_clearing || m_running || m_holding)) begin
      if (start && !abort) begin
        m_tgt      = target;
        m_clearing = 1'b1;
      end
    end else if (abort) begin
      m_clearing = 1'b0; m_running = 1'b0; m_holding = 1'b0;
    end else if (m_clearing) begin
      m_clearing = 1'b0;
      m_running  = 1'b1;
    end else if (m_running) begin
      if (m_reached()) begin
        m_running = 1'b0;
        m_holding = 1'b1;
        m_data    = cnt_m;
        m_ovf     = (m_tgt == '0);
      end
    end else if (res_ready) begin
      m_holding = 1'b0;
`ifdef CNT_RUN_CTRL_AUTORELOAD_EN
      m_clearing = 1'b1;
`endif
    end

    if (rst)                 cnt_m <= '0;
    else if (preload_req)    cnt_m <= preload_val;
    else if (bus_if.ctr_clr) cnt_m <= '0;
    else if (bus_if.ctr_en)  cnt_m <= cnt_m + 32'd1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkb("busy", busy, !rst && (m_clearing || m_running || m_holding));
      checkb("ctr_clr", bus_if.ctr_clr, !rst && m_clearing);
      checkb("ctr_en", bus_if.ctr_en, !rst && m_running && evt && !abort && !m_reached());
      checkb("res_valid", bus_if.res_valid, !rst && m_holding);
      check("res_data", bus_if.res_data, m_data);
      checkb("res_ovf", bus_if.res_ovf, m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: hold evt, 1: toggle evt each cycle, 2: random evt
  task automatic wait_valid(input int bound, input int mode, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus_if.res_valid) begin
        at = cyc;
        break;
      end
      @(posedge clk);
      #1;
      if (mode == 1) evt = ~evt;
      else if (mode == 2) evt = 1'($urandom);
    end
    checkb("valid_timeout", at >= 0, 1'b1);
  endtask

  task automatic finish_result();
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
`ifdef CNT_RUN_CTRL_AUTORELOAD_EN
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif
    @(negedge clk);
    checkb("idle_after_handshake", busy, 1'b0);
  endtask

  task automatic launch(input logic [W-1:0] tgt, output int t0);
    tick();
    t0     = cyc;
    start  = 1'b1;
    target = tgt;
    evt    = 1'b1;
    tick();
    start  = 1'b0;
    target = $urandom;
  endtask

  int t0, at, t1, t2;
  logic [W-1:0] saved;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; evt = 1'b0; res_ready = 1'b0;
    target = '0; preload_req = 1'b0; preload_val = '0;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    checkb("reset_busy", busy, 1'b0);
    checkb("reset_valid", bus_if.res_valid, 1'b0);
    check("reset_data", bus_if.res_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Target 5, evt held high
    launch(32'd5, t0);
    @(negedge clk);
    checkb("a_clr_t1", bus_if.ctr_clr, 1'b1);
    wait_valid(50, 0, at);
    check("a_latency", at - t0, 32'd8);
    check("a_data", bus_if.res_data, 32'd5);
    checkb("a_ovf", bus_if.res_ovf, 1'b0);
    check("a_cnt_hold", cnt_m, 32'd5);
    finish_result();

    // Target 4, evt toggling 1,0,1,0...
    launch(32'd4, t0);
    evt = 1'b0;
    wait_valid(50, 1, at);
    check("b_latency", at - t0, 32'd10);
    check("b_data", bus_if.res_data, 32'd4);
    finish_result();

    // Saturation run with preload near all-ones
    launch(32'd0, t0);
    tick();
    tick();
    preload_req = 1'b1;
    preload_val = 32'hFFFF_FFFD;
    tick();
    preload_req = 1'b0;
    wait_valid(50, 0, at);
    check("c_latency", at - t0, 32'd7);
    check("c_data", bus_if.res_data, 32'hFFFF_FFFF);
    checkb("c_ovf", bus_if.res_ovf, 1'b1);

    // Result held under back-pressure; start ignored
    saved = bus_if.res_data;
    for (int k = 0; k < 10; k++) begin
      tick();
      start = (k == 3);
      @(negedge clk);
      checkb("d_valid_hold", bus_if.res_valid, 1'b1);
      check("d_data_hold", bus_if.res_data, saved);
      check("d_no_wrap", cnt_m, 32'hFFFF_FFFF);
    end
    start = 1'b0;
    finish_result();

    // Abort during RUN at cnt=2
    launch(32'd6, t0);
    for (int i = 0; i < 20; i++) begin
      if (cnt_m == 32'd2) break;
      tick();
    end
    check("e_reach", cnt_m, 32'd2);
    abort = 1'b1;
    @(negedge clk);
    checkb("e_en_abort", bus_if.ctr_en, 1'b0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    checkb("e_idle", busy, 1'b0);
    checkb("e_no_valid", bus_if.res_valid, 1'b0);
    check("e_cnt_kept", cnt_m, 32'd2);

    // Abort during DONE
    launch(32'd2, t0);
    wait_valid(50, 0, at);
    @(posedge clk);
    #1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    checkb("f_idle", busy, 1'b0);
    checkb("f_no_valid", bus_if.res_valid, 1'b0);

    // Reset mid-run
    launch(32'd7, t0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkb("g_busy", busy, 1'b0);
    checkb("g_en", bus_if.ctr_en, 1'b0);
    checkb("g_clr", bus_if.ctr_clr, 1'b0);
    check("g_data", bus_if.res_data, 32'd0);

    // Restart behaviour with res_ready held high
    res_ready = 1'b1;
    launch(32'd3, t0);
    wait_valid(50, 0, t1);
    check("h_data1", bus_if.res_data, 32'd3);
`ifdef CNT_RUN_CTRL_AUTORELOAD_EN
    tick();
    wait_valid(50, 0, t2);
    check("h_period", t2 - t1, 32'd6);
    check("h_data2", bus_if.res_data, 32'd3);
    tick();
    wait_valid(50, 0, t1);
    check("h_period2", t1 - t2, 32'd6);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checkb("h_stopped", busy, 1'b0);
`else
    repeat (8) tick();
    @(negedge clk);
    checkb("h_no_restart", busy, 1'b0);
`endif
    res_ready = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 2) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      evt       = 1'($urandom);
      res_ready = 1'($urandom);
      target    = $urandom_range(1, 12);
    end
    tick();
    rst = 1'b0; start = 1'b0; abort = 1'b0; evt = 1'b0; res_ready = 1'b0;
    tick();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_run_ctrl.md
# cnt_run_ctrl

Sequencing controller for the free-running 32-bit event counter (ports `clr`, `en`, `cnt`, `cnt_max`). It clears the counter, gates its enable with an event qualifier until a programmed terminal count or saturation, then returns the captured count over a valid/ready result port. It sits between host/control logic and one counter instance; it is the only driver of that counter's `clr` and `en`.

## Interface
Parameters:
- `CNT_W`, 32, width of counter value, target and result.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a run; sampled only in IDLE.
- `abort`  in  1  cancel run or discard pending result; priority over every other event.
- `target`  in  CNT_W  terminal count, latched when `start` is accepted; 0 = run to saturation.
- `evt`  in  1  event qualifier; the counter advances only on cycles with `evt`=1 during RUN.
- `cnt`  in  CNT_W  counter value (registered output of the counter).
- `cnt_max`  in  1  counter all-ones flag.
- `ctr_clr`  out  1  to counter `clr`.
- `ctr_en`  out  1  to counter `en`.
- `busy`  out  1  high in CLR, RUN, DONE.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  CNT_W  captured count.
- `res_ovf`  out  1  run ended by saturation, not target.

## Operation
- States: IDLE, CLR, RUN, DONE. Reset → IDLE. `tgt_q`, `res_data`, `res_ovf` reset to 0. All outputs 0 in reset.
- IDLE: `start`=1 and `abort`=0 → latch `target` into `tgt_q`; next state CLR. Otherwise stay.
- CLR (one cycle): `ctr_clr`=1, `ctr_en`=0; next state RUN.
- RUN: `hit` = (`tgt_q`≠0) and (`cnt`==`tgt_q`); `sat` = (`tgt_q`==0) and `cnt_max`.
  - `ctr_en` = `evt` & ~`hit` & ~`sat` & ~`abort` (the counter never passes target and never wraps).
  - `abort` → IDLE, no result.
  - else `hit` → DONE; capture `res_data`←`cnt`, `res_ovf`←0.
  - else `sat` → DONE; capture `res_data`←`cnt` (all ones), `res_ovf`←1.
- DONE: `res_valid`=1; `res_data`/`res_ovf` stable until handshake. `res_valid` & `res_ready` → IDLE. `abort` → IDLE, result dropped.
- `ctr_clr`, `ctr_en`, `busy`, `res_valid` are combinational decodes of state and inputs; no other output glitches on input change.
- `start` outside IDLE is ignored (not queued). `target` changes after acceptance are ignored.
- Reset mid-run: IDLE next cycle, `ctr_en`=0, `ctr_clr`=0; the counter's own `rst` handles its value.

## Timing
- `start` accepted in cycle T → CLR in T+1 → `cnt`=0 and RUN in T+2.
- With `evt` held high and target N≥1: `cnt`=N in T+2+N, `ctr_en`=0 that cycle, `res_valid`=1 in T+3+N.
- Minimum start-to-start period (manual restart, `res_ready` tied high): N+4 cycles.
- `abort` sampled in cycle A → IDLE and `busy`=0 in A+1; `ctr_en`=0 already in A.

## Configuration
- `CNT_RUN_CTRL_AUTORELOAD_EN` defined: a DONE handshake goes to CLR, not IDLE, and reuses `tgt_q`. `busy` stays high, and runs repeat until `abort`. The restart period is N+3 cycles.
- Not defined: a DONE handshake goes to IDLE, and each run needs a new `start`.

## Test plan
The bench uses a behavioural counter model driven by `ctr_clr`/`ctr_en`, with a backdoor preload.
- Reset, then `start` with target=5 and `evt`=1 at T → `ctr_clr` at T+1; `res_valid` at T+8 with `res_data`=5 and `res_ovf`=0; the counter holds 5.
- Target=4, `evt` toggling 1,0,1,0… → `res_data`=4; `ctr_en` mirrors `evt` until the hit cycle; the run is longer by the count of idle cycles.
- Target=0, counter preloaded to 32'hFFFF_FFFD during RUN, `evt`=1 → `res_ovf`=1, `res_data`=32'hFFFF_FFFF; the counter never wraps to 0.
- `res_ready`=0 for 10 cycles in DONE → `res_valid` and `res_data` stable; a `start` pulse is ignored; ready=1 → IDLE next cycle.
- `abort` in RUN at cnt=2, and `abort` in DONE → IDLE next cycle, no handshake, `ctr_en`=0 in the abort cycle. `rst` mid-RUN → all outputs 0 next cycle.
- With `CNT_RUN_CTRL_AUTORELOAD_EN` defined and target=3 → back-to-back results of 3, each `res_valid` 6 cycles apart with `res_ready`=1; `abort` stops the sequence.
